// File: rtl/cla6_bit_cla3_block.sv
// cla3_block -- 3-bit carry-lookahead slice.
// Forms per-bit generate/propagate, computes its two internal carries as
// flat sums of products from cin, and exports group generate/propagate
// so a second-level lookahead unit can produce the carry into the next slice.
//
// Ports:
//   a[2:0], b[2:0] : addend bits for this slice
//   cin            : carry into bit 0 of the slice
//   s[2:0]         : sum bits of the slice
//   G              : group generate (slice produces a carry by itself)
//   P              : group propagate (slice passes cin straight through)
module cla3_block (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       G,
  output logic       P
);

  logic [2:0] g;
  logic [2:0] p;
  logic [2:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded directly from cin; none depends on a neighbouring
  // carry, so the slice has no ripple path.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);

  assign s = p ^ c;

  assign G = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
  assign P = &p;

endmodule

// File: rtl/cla6_bit.sv
// cla6_bit -- 6-bit two-level carry-lookahead adder with a registered output.
// Two cla3_block slices cover bits [2:0] and [5:3]; a second-level lookahead
// unit derives the carry into the upper slice and the final carry-out from
// the group generate/propagate terms. Result is registered: 1-cycle latency,
// new operation every cycle, no enable.
//
// Ports:
//   A[5:0], B[5:0] : unsigned addends
//   c0             : carry-in
//   S[5:0]         : registered sum (A+B+c0) mod 64
//   c_out          : registered carry-out (sum bit 6)
//   clk            : rising-edge clock for the output register
//   rst_n          : asynchronous active-low reset, clears S and c_out
module cla6_bit (
  input  logic [5:0] A,
  input  logic [5:0] B,
  input  logic       c0,
  output logic [5:0] S,
  output logic       c_out,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int WIDTH = 6;

  logic             g_lo;
  logic             p_lo;
  logic             g_hi;
  logic             p_hi;
  logic             c3;
  logic [WIDTH-1:0] sum_p0;
  logic             cout_p0;

  cla3_block u_lo (
    .a   (A[2:0]),
    .b   (B[2:0]),
    .cin (c0),
    .s   (sum_p0[2:0]),
    .G   (g_lo),
    .P   (p_lo)
  );

  cla3_block u_hi (
    .a   (A[5:3]),
    .b   (B[5:3]),
    .cin (c3),
    .s   (sum_p0[5:3]),
    .G   (g_hi),
    .P   (p_hi)
  );

  // Second-level lookahead: both group carries come straight from c0 and
  // the group terms, so carry-out does not wait on the upper slice's cin.
  assign c3      = g_lo | (p_lo & c0);
  assign cout_p0 = g_hi | (p_hi & g_lo) | (p_hi & p_lo & c0);

  // ---- stage p0 -> output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S     <= '0;
      c_out <= 1'b0;
    end else begin
      S     <= sum_p0;
      c_out <= cout_p0;
    end
  end

endmodule

// File: tb/tb_cla6_bit.sv
module tb_cla6_bit;

  logic [5:0] A;
  logic [5:0] B;
  logic       c0;
  logic [5:0] S;
  logic       c_out;
  logic       clk;
  logic       rst_n;

  int passed = 0;
  int total  = 0;

  cla6_bit dut (
    .A     (A),
    .B     (B),
    .c0    (c0),
    .S     (S),
    .c_out (c_out),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] a;
    logic [5:0] b;
    logic       c;
    logic [5:0] s;
    logic       co;
  } vec_t;

  // Reference model: plain 7-bit arithmetic sum.
  function automatic logic [6:0] model(input logic [5:0] a, input logic [5:0] b,
                                       input logic c);
    int sum;
    sum = int'(a) + int'(b) + int'(c);
    return 7'(sum);
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {c_out,S}=%0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
  endtask

  // Drive inputs just after an edge, then sample 1 ns after the next edge.
  task automatic apply_and_check(input string name, input logic [5:0] a,
                                 input logic [5:0] b, input logic c,
                                 input logic [6:0] exp);
    A = a; B = b; c0 = c;
    @(posedge clk); #1;
    check(name, {c_out, S}, exp);
  endtask

  vec_t vecs[5];
  logic [6:0] exp_q[$];

  initial begin
    A = '0; B = '0; c0 = 1'b0; rst_n = 1'b0;

    // Reset state, with the clock running.
    @(posedge clk); #1;
    check("reset_state", {c_out, S}, 7'd0);
    A = 6'd63; B = 6'd63; c0 = 1'b1;
    @(posedge clk); #1;
    check("reset_hold_ignores_inputs", {c_out, S}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_after_reset", {c_out, S}, 7'd127);

    // Directed table.
    vecs[0] = '{"full_carry_chain",    6'd63, 6'd1,  1'b0, 6'd0,  1'b1};
    vecs[1] = '{"all_propagate_cin",   6'd21, 6'd42, 1'b1, 6'd0,  1'b1};
    vecs[2] = '{"group_boundary",      6'd7,  6'd1,  1'b0, 6'd8,  1'b0};
    vecs[3] = '{"max_operands",        6'd63, 6'd63, 1'b1, 6'd63, 1'b1};
    vecs[4] = '{"zero_operands",       6'd0,  6'd0,  1'b0, 6'd0,  1'b0};
    for (int i = 0; i < 5; i++)
      apply_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c,
                      {vecs[i].co, vecs[i].s});

    // Exhaustive sweep against the model.
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 64; a++)
        for (int b = 0; b < 64; b++)
          apply_and_check("exhaustive", 6'(a), 6'(b), 1'(c),
                          model(6'(a), 6'(b), 1'(c)));

    // Back-to-back random operations: each edge must show the sum of the
    // inputs applied in the previous cycle, no bubbles.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] ra, rb;
      logic       rc;
      ra = 6'($urandom_range(63));
      rb = 6'($urandom_range(63));
      rc = 1'($urandom_range(1));
      A = ra; B = rb; c0 = rc;
      exp_q.push_back(model(ra, rb, rc));
      @(posedge clk); #1;
      check("stream_latency", {c_out, S}, exp_q.pop_front());
    end

    // Asynchronous reset between edges with A=B=63, result pending.
    A = 6'd63; B = 6'd63; c0 = 1'b0;
    @(posedge clk); #1;
    check("pre_async_reset", {c_out, S}, 7'd126);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", {c_out, S}, 7'd0);
    @(posedge clk); #1;
    check("async_reset_discards", {c_out, S}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge_yet", {c_out, S}, 7'd0);
    @(posedge clk); #1;
    check("reset_release_capture", {c_out, S}, 7'd126);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, passed=%0d total=%0d",
             passed, total);
    $fatal(1);
  end

endmodule
